// File: rtl/fc_mac_ctrl.sv
// fc_mac_ctrl: sequencer for the binary fully-connected MAC stage of the VAD
// classifier. It takes one binarized feature frame, streams it to the MAC as
// LANES-bit slices over SEG steps along with the weight step index, waits out
// the MAC latency, compares the two class scores and presents a speech /
// non-speech decision on a valid/ready output.
//
// Optional feature: define FC_MAC_CTRL_HANGOVER_EN to hold the speech flag for
// HANGOVER frames after the last raw speech decision. Without the macro the
// flag is the raw score comparison and no hangover counter exists.
//
// Every output comes straight from a register. The registers are loaded from
// the next-state decode, so each output is valid in the same cycle as the
// state it belongs to.

module fc_mac_ctrl #(
  parameter int FEAT_W   = 108,
  parameter int LANES    = 3,
  parameter int SEG      = 36,
  parameter int ACC_W    = 8,
  parameter int MAC_LAT  = 1,
  parameter int HANGOVER = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              feat_valid,
  output logic              feat_ready,
  input  logic [FEAT_W-1:0] feat_data,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [LANES-1:0]  mac_in,
  output logic [5:0]        mac_addr,
  input  logic [ACC_W-1:0]  sum0,
  input  logic [ACC_W-1:0]  sum1,
  output logic              vad_valid,
  input  logic              vad_ready,
  output logic              vad_flag,
  output logic              busy
);

  localparam int IDX_W = (FEAT_W > 1) ? $clog2(FEAT_W) : 1;
  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [5:0]       LAST_K   = 6'(SEG - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(MAC_LAT - 1);

  // Elaboration stops on a configuration the sequencer cannot honour.
  if ((FEAT_W != LANES * SEG) || (SEG < 1) || (SEG > 64) ||
      (MAC_LAT < 1) || (HANGOVER < 0)) begin : g_bad_cfg
    $error("fc_mac_ctrl: inconsistent parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DECIDE = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  // Lane j carries frame bit (j+1)*SEG-1-k, so each lane walks its own
  // SEG-bit segment from the MSB downwards.
  function automatic logic [LANES-1:0] slice_lanes(
    input logic [FEAT_W-1:0] frame,
    input logic [5:0]        k
  );
    logic [LANES-1:0] lanes;
    int               bit_pos;
    lanes = {LANES{1'b0}};
    for (int j = 0; j < LANES; j++) begin
      bit_pos  = (j + 1) * SEG - 1 - int'(k);
      lanes[j] = frame[bit_pos[IDX_W-1:0]];
    end
    return lanes;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_k;
  logic [5:0]         w_k_nxt;
  logic [LAT_W-1:0]   r_lat;
  logic [LAT_W-1:0]   w_lat_nxt;
  logic               w_capture;
  logic [FEAT_W-1:0]  r_frame;

  logic               r_feat_ready;
  logic               r_mac_clr;
  logic               r_mac_en;
  logic [LANES-1:0]   r_mac_in;
  logic [5:0]         r_mac_addr;
  logic               r_vad_valid;
  logic               r_vad_flag;
  logic               r_busy;

  logic               w_decide;
  logic               w_raw;
  logic               w_flag_nxt;

  // Next-state, step counter and latency counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_lat_nxt   = r_lat;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // abort blocks an accept offered in the same cycle
        if (feat_valid && !abort) begin
          w_state_nxt = ST_LOAD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
          w_k_nxt     = 6'd0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_k == LAST_K) begin
          w_state_nxt = ST_WAIT;
          w_lat_nxt   = {LAT_W{1'b0}};
        end else begin
          w_k_nxt = r_k + 6'd1;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_lat == LAST_LAT) begin
          w_state_nxt = ST_DECIDE;
        end else begin
          w_lat_nxt = r_lat + {{(LAT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DECIDE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (vad_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Raw decision: strictly greater speech score wins, a tie is non-speech.
  always_comb begin
    w_decide = (r_state == ST_DECIDE) && !abort;
    w_raw    = ($signed(sum1) > $signed(sum0));
  end

`ifdef FC_MAC_CTRL_HANGOVER_EN
  localparam int HANG_W = (HANGOVER > 0) ? $clog2(HANGOVER + 1) : 1;
  localparam logic [HANG_W-1:0] HANG_LOAD = HANG_W'(HANGOVER);

  logic [HANG_W-1:0] r_hang;
  logic [HANG_W-1:0] w_hang_nxt;

  // Flag with hangover: speech is held while the counter drains.
  always_comb begin
    w_flag_nxt = r_vad_flag;
    w_hang_nxt = r_hang;
    if (w_decide) begin
      if (w_raw) begin
        w_flag_nxt = 1'b1;
        w_hang_nxt = HANG_LOAD;
      end else if (r_hang != {HANG_W{1'b0}}) begin
        w_flag_nxt = 1'b1;
        w_hang_nxt = r_hang - {{(HANG_W-1){1'b0}}, 1'b1};
      end else begin
        w_flag_nxt = 1'b0;
      end
    end else begin
      w_flag_nxt = r_vad_flag;
    end
  end

  // Hangover counter survives abort; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hang <= {HANG_W{1'b0}};
    end else begin
      r_hang <= w_hang_nxt;
    end
  end
`else
  // Flag without hangover: the raw comparison, captured in DECIDE only.
  always_comb begin
    if (w_decide) begin
      w_flag_nxt = w_raw;
    end else begin
      w_flag_nxt = r_vad_flag;
    end
  end
`endif

  // State, counters, frame capture and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_k          <= 6'd0;
      r_lat        <= {LAT_W{1'b0}};
      r_frame      <= {FEAT_W{1'b0}};
      r_feat_ready <= 1'b1;
      r_mac_clr    <= 1'b0;
      r_mac_en     <= 1'b0;
      r_mac_in     <= {LANES{1'b0}};
      r_mac_addr   <= 6'd0;
      r_vad_valid  <= 1'b0;
      r_vad_flag   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_lat      <= w_lat_nxt;
      r_vad_flag <= w_flag_nxt;
      if (w_capture) begin
        r_frame <= feat_data;
      end else begin
        r_frame <= r_frame;
      end
      r_feat_ready <= (w_state_nxt == ST_IDLE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_mac_clr    <= (w_state_nxt == ST_LOAD);
      r_vad_valid  <= (w_state_nxt == ST_OUT);
      if (w_state_nxt == ST_RUN) begin
        r_mac_en   <= 1'b1;
        r_mac_addr <= w_k_nxt;
        r_mac_in   <= slice_lanes(r_frame, w_k_nxt);
      end else begin
        r_mac_en   <= 1'b0;
        r_mac_addr <= 6'd0;
        r_mac_in   <= {LANES{1'b0}};
      end
    end
  end

  assign feat_ready = r_feat_ready;
  assign mac_clr    = r_mac_clr;
  assign mac_en     = r_mac_en;
  assign mac_in     = r_mac_in;
  assign mac_addr   = r_mac_addr;
  assign vad_valid  = r_vad_valid;
  assign vad_flag   = r_vad_flag;
  assign busy       = r_busy;

endmodule

// File: doc/fc_mac_ctrl.md
# fc_mac_ctrl

Sequencer for the binary fully-connected MAC stage of the VAD classifier. It accepts one 108-bit binarized feature frame and streams it to the MAC as 3-bit lane slices over 36 cycles, together with the weight index. It then waits out the MAC latency, compares the two class scores and presents a speech/non-speech decision on a valid/ready output. It sits between the binarized feature buffer and the decision/output logic.

## Interface
- FEAT_W, 108: feature frame width in bits; must equal LANES*SEG.
- LANES, 3: MAC input lanes per cycle.
- SEG, 36: bits per lane, equal to MAC steps per frame.
- ACC_W, 8: width of each signed MAC class score.
- MAC_LAT, 1: cycles from the last `mac_en` until `sum0`/`sum1` are final. Minimum 1.
- HANGOVER, 4: frames of speech hold after the last speech frame (used only with the macro).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- abort  in  1  synchronous frame cancel.
- feat_valid  in  1  feature frame offered.
- feat_ready  out  1  controller can accept a frame.
- feat_data  in  FEAT_W  binarized features; bit FEAT_W-1 is first.
- mac_clr  out  1  clear MAC accumulators.
- mac_en  out  1  MAC accumulates this cycle.
- mac_in  out  LANES  lane bits for this step.
- mac_addr  out  6  weight step index, 0..SEG-1.
- sum0, sum1  in  ACC_W  signed class scores (non-speech, speech).
- vad_valid  out  1  decision available.
- vad_ready  in  1  consumer takes the decision.
- vad_flag  out  1  1 = speech.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, RUN, WAIT, DECIDE, OUT.
- IDLE
  - `feat_ready`=1.
  - On `feat_valid`&&`feat_ready`: register `feat_data` and go to LOAD.
- LOAD (1 cycle): `mac_clr`=1, `mac_en`=0; step counter k=0. Then go to RUN.
- RUN (SEG cycles): `mac_en`=1 and `mac_addr`=k.
  - Lane j (j=LANES-1..0) drives `mac_in[j]` = frame bit (j+1)*SEG-1-k.
  - With defaults, step k gives `mac_in` = {f[107-k], f[71-k], f[35-k]}.
  - After k=SEG-1, go to WAIT.
- WAIT (MAC_LAT cycles): `mac_en`=0, `mac_in`=0. Then go to DECIDE.
- DECIDE (1 cycle): compute raw = ($signed(`sum1`) > $signed(`sum0`)). A tie gives 0. Register the result into `vad_flag`, then go to OUT.
- OUT: `vad_valid`=1.
  - `vad_flag` stays stable until `vad_valid`&&`vad_ready`; then go to IDLE.
  - `feat_valid` is ignored while in OUT.
- `abort` in any non-IDLE state: next cycle is IDLE.
  - `mac_en`, `mac_clr` and `vad_valid` drop to 0.
  - The captured frame is discarded.
  - `abort` in IDLE has no effect; `abort` wins over an accept in the same cycle.
- Outside RUN: `mac_in`=0, `mac_addr`=0, `mac_en`=0.

## Timing
- Reset values:
  - State IDLE, `feat_ready`=1.
  - `mac_clr`=0, `mac_en`=0, `mac_in`=0, `mac_addr`=0.
  - `vad_valid`=0, `vad_flag`=0, `busy`=0, hangover counter 0.
- `rst` mid-frame takes priority over everything; the frame is lost.
- Accept in cycle 0 gives this sequence:
  - LOAD in cycle 1.
  - RUN in cycles 2..SEG+1.
  - WAIT in cycles SEG+2..SEG+MAC_LAT+1.
  - DECIDE in cycle SEG+MAC_LAT+2.
  - `vad_valid` first high in cycle SEG+MAC_LAT+3; this is 40 with defaults.
- `sum0`/`sum1` are sampled only in DECIDE.
- All outputs are registered.
- Throughput: at most one frame per SEG+MAC_LAT+4 cycles. The return to IDLE costs one cycle after the OUT handshake.

## Configuration
- `FC_MAC_CTRL_HANGOVER_EN` defined:
  - On raw=1: set `vad_flag`=1 and reload the hangover counter to HANGOVER.
  - On raw=0 with counter>0: set `vad_flag`=1 and decrement the counter.
  - On raw=0 with counter=0: set `vad_flag`=0.
  - The counter updates only in DECIDE.
  - `abort` does not clear the counter; `rst` does.
- Not defined: `vad_flag` = raw. No counter is built and HANGOVER is ignored.

## Test plan
- Single frame, all-ones `feat_data`, `sum0`=-5, `sum1`=3, `vad_ready`=1 → `mac_clr` pulse in cycle 1; `mac_in`=3'b111 with `mac_addr` 0..35 in cycles 2..37; `vad_valid`=1 with `vad_flag`=1 in cycle 40.
- Slicing: only bits 107 and 0 set → `mac_in`=3'b100 at k=0, 3'b001 at k=35, 3'b000 on all other steps.
- Signed compare: `sum0`=`sum1`=7 → flag 0. `sum0`=-128 (8'h80), `sum1`=127 → flag 1. `sum0`=1, `sum1`=-1 → flag 0.
- Backpressure: `vad_ready` held low for 10 cycles with `feat_valid`=1 → `vad_valid` and `vad_flag` stable, `feat_ready`=0. One cycle after `vad_ready`: IDLE, `feat_ready`=1, and the next frame is accepted.
- `abort` at RUN k=20 → next cycle `mac_en`=0, `feat_ready`=1, no `vad_valid`. A following frame runs a full 36 steps from k=0. `rst` at k=10 gives all reset values the next cycle.
- With the macro and HANGOVER=2, raw sequence 1,0,0,0 → flags 1,1,1,0. Without the macro, the same sequence gives 1,0,0,0.
